// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types and widths for the fetch/decode front end.
package cpu_pkg;
  localparam int PC_W = 16;
  localparam int INSTR_W = 32;
  localparam logic [3:0] OPC_BRANCH = 4'b0011;

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetchState_t;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid holding an acked instruction the stalled IF/ID register could not take.
// Latency: one cycle from load to valid; clear takes priority over load.
module fetch_skid_buf #(
  parameter int PC_W = cpu_pkg::PC_W,
  parameter int INSTR_W = cpu_pkg::INSTR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] loadData,
  input  logic [PC_W-1:0]    loadPc,
  output logic [INSTR_W-1:0] data,
  output logic [PC_W-1:0]    pc,
  output logic               valid
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
      pc    <= loadPc;
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one request in flight, IF/ID register updated once per acked fetch, one per cycle.
// A stall with data in hand parks it in the skid; a branch flushes IF/ID and drains any un-acked request.
module fetch_stage #(
  parameter int PC_W = 16,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stop_i,
  input  logic               sel_branch_i,
  input  logic [PC_W-1:0]    branch_target_i,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic [PC_W-1:0]    ifid_pc_o,
  output logic               ifid_valid_o,
  output logic [3:0]         opcode_o
);
  import cpu_pkg::*;

  fetchState_t state, stateNxt;
  logic [PC_W-1:0]    pc, pcNxt, addrNxt, ifidPcNxt, pcInc;
  logic [INSTR_W-1:0] ifidInstrNxt, skidData;
  logic [PC_W-1:0]    skidPc;
  logic               ifidValidNxt, skidValid, skidLoad, skidClear;
  logic               awake;

  fetch_skid_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W)) skidBuf (
    .clk      (clk),
    .reset    (reset),
    .load     (skidLoad),
    .clear    (skidClear),
    .loadData (imem_rdata_i),
    .loadPc   (imem_addr_o),
    .data     (skidData),
    .pc       (skidPc),
    .valid    (skidValid)
  );

  assign pcInc      = pc + PC_W'(4);
  assign imem_req_o = (state == REQ) || (state == DRAIN);
  assign opcode_o   = ifid_valid_o ? ifid_instr_o[INSTR_W-1 -: 4] : 4'b0000;

  // awake holds IDLE for one extra cycle after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      imem_addr_o  <= RESET_PC;
      ifid_instr_o <= '0;
      ifid_pc_o    <= '0;
      ifid_valid_o <= 1'b0;
      awake        <= 1'b0;
    end else begin
      state        <= stateNxt;
      pc           <= pcNxt;
      imem_addr_o  <= addrNxt;
      ifid_instr_o <= ifidInstrNxt;
      ifid_pc_o    <= ifidPcNxt;
      ifid_valid_o <= ifidValidNxt;
      awake        <= 1'b1;
    end
  end

  always_comb begin
    stateNxt     = state;
    pcNxt        = pc;
    addrNxt      = imem_addr_o;
    ifidInstrNxt = ifid_instr_o;
    ifidPcNxt    = ifid_pc_o;
    ifidValidNxt = ifid_valid_o;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    if (sel_branch_i) begin
      pcNxt        = branch_target_i & ~PC_W'(3);
      ifidValidNxt = 1'b0;
      skidClear    = 1'b1;
      stateNxt     = (state == REQ && !imem_ack_i) ? DRAIN : IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!stop_i && awake) begin
            stateNxt = REQ;
            addrNxt  = pc;
          end
        end
        REQ: begin
          if (imem_ack_i && !stop_i) begin
            ifidInstrNxt = imem_rdata_i;
            ifidPcNxt    = imem_addr_o;
            ifidValidNxt = 1'b1;
            pcNxt        = pcInc;
            addrNxt      = pcInc;
          end else if (imem_ack_i) begin
            skidLoad = 1'b1;
            stateNxt = HOLD;
          end else if (!stop_i) begin
            ifidValidNxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stop_i && skidValid) begin
            ifidInstrNxt = skidData;
            ifidPcNxt    = skidPc;
            ifidValidNxt = 1'b1;
            skidClear    = 1'b1;
            pcNxt        = pcInc;
            stateNxt     = IDLE;
          end
        end
        DRAIN: begin
          if (imem_ack_i) stateNxt = IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed walk through fetch scenarios, then random stall/ack/branch traffic against a fetch-order scoreboard.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stop_i, sel_branch_i, imem_ack_i;
  logic [15:0] branch_target_i;
  logic [31:0] imem_rdata_i;
  logic        imem_req_o, ifid_valid_o;
  logic [15:0] imem_addr_o, ifid_pc_o;
  logic [31:0] ifid_instr_o;
  logic [3:0]  opcode_o;

  int errors = 0;
  int checks = 0;
  logic [15:0] pending[$];

  fetch_stage dut (
    .clk(clk), .reset(reset), .stop_i(stop_i), .sel_branch_i(sel_branch_i),
    .branch_target_i(branch_target_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i), .ifid_instr_o(ifid_instr_o),
    .ifid_pc_o(ifid_pc_o), .ifid_valid_o(ifid_valid_o), .opcode_o(opcode_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [15:0] a);
    return {a[5:2], 12'h5A5, a};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expIfid(input string tag, input logic [15:0] pc, input logic [31:0] instr, input logic v);
    logic [31:0] w;
    w = instr;
    check({tag, "_pc"}, ifid_pc_o, pc);
    check({tag, "_instr"}, ifid_instr_o, instr);
    check({tag, "_valid"}, ifid_valid_o, v);
    check({tag, "_opc"}, opcode_o, v ? w[31:28] : 4'h0);
  endtask

  initial begin
    logic [15:0] expNext, drainAddr, addrB, pcB, front;
    logic [31:0] instrB, word, expPc;
    logic        reqB, validB, draining, nextDrain, tail;
    int          deliveries;

    reset = 1'b1; stop_i = 1'b0; sel_branch_i = 1'b0; branch_target_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
    tick(); tick();
    check("rst_req", imem_req_o, 0);
    check("rst_addr", imem_addr_o, 16'h0000);
    expIfid("rst", 16'h0000, 32'h0, 1'b0);

    reset = 1'b0;
    tick();
    check("wake1_req", imem_req_o, 0);
    tick();
    check("wake2_req", imem_req_o, 1);
    check("wake2_addr", imem_addr_o, 16'h0000);

    // back-to-back single-cycle acks
    imem_ack_i = 1'b1; imem_rdata_i = 32'h1000_0000;
    tick();
    expIfid("b2b0", 16'h0000, 32'h1000_0000, 1'b1);
    check("b2b0_addr", imem_addr_o, 16'h0004);
    imem_rdata_i = 32'h2000_0000;
    tick();
    expIfid("b2b1", 16'h0004, 32'h2000_0000, 1'b1);
    check("b2b1_addr", imem_addr_o, 16'h0008);

    // late ack
    imem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_req", imem_req_o, 1);
      check("wait_addr", imem_addr_o, 16'h0008);
      check("wait_valid", ifid_valid_o, 0);
    end
    imem_ack_i = 1'b1; imem_rdata_i = 32'h3000_0000;
    tick();
    expIfid("late", 16'h0008, 32'h3000_0000, 1'b1);
    check("late_addr", imem_addr_o, 16'h000C);

    // stall with data in hand
    stop_i = 1'b1; imem_rdata_i = 32'h4000_0000;
    tick();
    check("hold_req", imem_req_o, 0);
    expIfid("hold0", 16'h0008, 32'h3000_0000, 1'b1);
    imem_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_req", imem_req_o, 0);
      expIfid("hold", 16'h0008, 32'h3000_0000, 1'b1);
    end
    stop_i = 1'b0;
    tick();
    expIfid("release", 16'h000C, 32'h4000_0000, 1'b1);
    check("release_req", imem_req_o, 0);
    tick();
    check("next_req", imem_req_o, 1);
    check("next_addr", imem_addr_o, 16'h0010);

    imem_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdata_i = 32'h5000_0000 + 32'(i);
      tick();
    end
    expIfid("run", 16'h001C, 32'h5000_0003, 1'b1);
    check("run_addr", imem_addr_o, 16'h0020);
    imem_ack_i = 1'b0;
    tick();
    expIfid("bubble", 16'h001C, 32'h5000_0003, 1'b0);

    // branch under stall with a request outstanding
    sel_branch_i = 1'b1; stop_i = 1'b1; branch_target_i = 16'h0043;
    tick();
    check("drain_req", imem_req_o, 1);
    check("drain_addr", imem_addr_o, 16'h0020);
    expIfid("flush", 16'h001C, 32'h5000_0003, 1'b0);
    sel_branch_i = 1'b0;
    tick();
    check("drain2_req", imem_req_o, 1);
    check("drain2_addr", imem_addr_o, 16'h0020);
    imem_ack_i = 1'b1; imem_rdata_i = 32'hF000_0000;
    tick();
    check("drained_req", imem_req_o, 0);
    expIfid("drained", 16'h001C, 32'h5000_0003, 1'b0);
    imem_ack_i = 1'b0;
    tick();
    check("stopidle_req", imem_req_o, 0);
    stop_i = 1'b0;
    tick();
    check("target_req", imem_req_o, 1);
    check("target_addr", imem_addr_o, 16'h0040);

    // branch coincident with ack, then PC wrap
    sel_branch_i = 1'b1; branch_target_i = 16'hFFFE; imem_ack_i = 1'b1; imem_rdata_i = 32'h7000_0000;
    tick();
    check("brack_req", imem_req_o, 0);
    expIfid("brack", 16'h001C, 32'h5000_0003, 1'b0);
    sel_branch_i = 1'b0; imem_ack_i = 1'b0;
    tick();
    check("wrapreq_addr", imem_addr_o, 16'hFFFC);
    imem_ack_i = 1'b1; imem_rdata_i = 32'h8000_0000;
    tick();
    expIfid("wrap", 16'hFFFC, 32'h8000_0000, 1'b1);
    check("wrap_addr", imem_addr_o, 16'h0000);

    // asynchronous reset mid-request
    imem_ack_i = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_req", imem_req_o, 0);
    check("async_addr", imem_addr_o, 16'h0000);
    expIfid("async", 16'h0000, 32'h0, 1'b0);
    imem_ack_i = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("ackign_req", imem_req_o, 0);
    expIfid("ackign", 16'h0000, 32'h0, 1'b0);
    tick();
    check("ackign2_req", imem_req_o, 1);
    check("ackign2_valid", ifid_valid_o, 0);
    imem_ack_i = 1'b0;

    // random traffic; DUT now requesting address 0 with nothing in flight
    expNext = 16'h0000; drainAddr = 16'h0000; draining = 1'b0; deliveries = 0;
    for (int n = 0; n < 3000; n++) begin
      tail = (n >= 2980);
      stop_i = tail ? 1'b0 : ($urandom_range(0, 3) == 0);
      sel_branch_i = tail ? 1'b0 : ($urandom_range(0, 39) == 0);
      branch_target_i = 16'($urandom);
      imem_ack_i = tail ? 1'b1 : ($urandom_range(0, 2) != 0);
      imem_rdata_i = memWord(imem_addr_o);
      reqB = imem_req_o; addrB = imem_addr_o;
      pcB = ifid_pc_o; instrB = ifid_instr_o; validB = ifid_valid_o;
      tick();
      if (sel_branch_i) begin
        check("rnd_flush_valid", ifid_valid_o, 0);
        pending.delete();
        nextDrain = reqB && !imem_ack_i && !draining;
        if (nextDrain) drainAddr = addrB;
        draining = nextDrain;
        expNext = branch_target_i & 16'hFFFC;
      end else begin
        if (reqB && draining) begin
          check("rnd_drain_addr", addrB, drainAddr);
          if (imem_ack_i) draining = 1'b0;
        end else if (reqB && imem_ack_i) begin
          check("rnd_fetch_addr", addrB, expNext);
          pending.push_back(addrB);
          expNext = expNext + 16'd4;
        end
        if (stop_i) begin
          check("rnd_stall_pc", ifid_pc_o, pcB);
          check("rnd_stall_instr", ifid_instr_o, instrB);
          check("rnd_stall_valid", ifid_valid_o, validB);
        end else begin
          if (ifid_valid_o && (!validB || ifid_pc_o != pcB)) begin
            deliveries++;
            if (pending.size() != 0) begin
              front = pending.pop_front();
              expPc = {16'h0, front};
            end else begin
              front = 16'h0;
              expPc = 32'hDEAD_0000;
            end
            word = memWord(front);
            check("rnd_deliv_pc", ifid_pc_o, expPc);
            check("rnd_deliv_instr", ifid_instr_o, word);
            check("rnd_deliv_opc", opcode_o, word[31:28]);
          end
          check("rnd_undelivered", pending.size(), 0);
        end
        if (!ifid_valid_o) check("rnd_bubble_opc", opcode_o, 0);
      end
    end
    check("rnd_end_empty", pending.size(), 0);
    check("rnd_liveness", deliveries > 200, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
